// File: rtl/wb_cmd_pkg.sv
// Shared types for the command-to-Wishbone master: FSM states, the response
// bundle and the timeout counter sizing helper.
package wb_cmd_pkg;

    // Widest data bus the response bundle can carry; narrower buses zero-extend.
    localparam int RSP_DATA_MAX = 64;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } rsp_t;

    function automatic int tmo_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic single-transfer Wishbone bus with pipelined stall.
interface wishbone_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    stall;
    logic                    ack;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, rdata, err
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, rdata, err
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Turns one valid/ready command into one Wishbone transaction and returns the
// outcome (data, err, timeout) on a valid/ready response stream.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_we,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_sel,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_rsp_timeout,
    wishbone_if.master              wb
);
    localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);

    state_t                  r_state, w_state_nxt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_sel;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_inc;
    rsp_t                    r_rsp, w_rsp_nxt;
    logic                    w_cmd_ready, w_accept, w_capture, w_take, w_tmo;
    logic                    w_cyc, w_stb, w_rsp_valid;
    logic                    w_unused_rsp;

    // The count after this edge; abort fires only if it reaches the limit with
    // no usable ack/err, so an ack on that very edge still wins.
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_tmo     = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CW'(TIMEOUT_CYCLES));
    assign w_accept  = w_cmd_ready && i_cmd_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        w_rsp_valid = 1'b0;
        w_take      = 1'b0;
        w_capture   = 1'b0;
        w_rsp_nxt   = '0;
        unique case (r_state)
            IDLE: begin
                w_cmd_ready = !i_rst;
                if (i_cmd_valid && !i_rst) w_state_nxt = REQ;
            end
            REQ: begin
                w_cyc  = 1'b1;
                w_stb  = 1'b1;
                // A stalled strobe was not taken, so ack/err with it mean nothing.
                w_take = !wb.stall && (wb.ack || wb.err);
                if (w_take || w_tmo) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end else if (!wb.stall) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_cyc  = 1'b1;
                w_take = wb.ack || wb.err;
                if (w_take || w_tmo) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (i_rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_take) begin
            w_rsp_nxt.err = wb.err;
            if (wb.ack && !wb.err && !r_we) w_rsp_nxt.rdata = RSP_DATA_MAX'(wb.rdata);
        end else begin
            w_rsp_nxt.err     = 1'b1;
            w_rsp_nxt.timeout = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rsp   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= i_cmd_we;
                r_addr  <= i_cmd_addr;
                r_wdata <= i_cmd_wdata;
                r_sel   <= i_cmd_sel;
                r_cnt   <= '0;
            end else if (r_state == REQ || r_state == WAIT) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_capture) r_rsp <= w_rsp_nxt;
        end
    end

    assign o_cmd_ready   = w_cmd_ready;
    assign o_rsp_valid   = w_rsp_valid;
    assign o_rsp_rdata   = r_rsp.rdata[DATA_WIDTH-1:0];
    assign o_rsp_err     = r_rsp.err;
    assign o_rsp_timeout = r_rsp.timeout;

    // Bits above DATA_WIDTH are always zero; fold them so they are consumed.
    assign w_unused_rsp  = |r_rsp.rdata;

    assign wb.cyc   = w_cyc;
    assign wb.stb   = w_stb;
    assign wb.we    = r_we;
    assign wb.addr  = r_addr;
    assign wb.wdata = r_wdata;
    assign wb.sel   = r_sel;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised scoreboard bench: a planned slave per transaction, a reference
// outcome model, and an independent response monitor.
module tb_wb_cmd_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [DW/8-1:0] cmd_sel = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, rsp_timeout;

    wishbone_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb();

    wb_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_sel(cmd_sel),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout), .wb(wb)
    );

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;
    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] sel;
        int              s;      // stall cycles before the strobe is taken
        int              w;      // wait cycles after it before ack/err
        kind_e           kind;
        logic [DW-1:0]   rd;
        bit              noise;  // ack asserted during stall cycles
        bit              abort;  // killed by reset, no response expected
    } txn_t;
    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            lat;      // edges from accept to response
        int            acc;
    } exp_t;

    txn_t slv_q[$];
    exp_t sb_q[$];
    int   n_chk = 0, n_err = 0;
    int   ecnt = 0;
    int   rr_mode = 0;           // 0 random, 1 hold low, 2 always ready
    bit   stray = 1'b0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Outcome from the bus plan: the response lands on edge s+w+1 after the
    // accept unless that is beyond the limit or the slave never answers.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   edges = t.s + t.w + 1;
        e.acc = 0;
        if (t.kind != K_NONE && (T == 0 || edges <= T)) begin
            e.err   = (t.kind == K_ERR || t.kind == K_BOTH);
            e.to    = 1'b0;
            e.rdata = (!t.we && t.kind == K_ACK) ? t.rd : '0;
            e.lat   = edges;
        end else begin
            e.err   = 1'b1;
            e.to    = 1'b1;
            e.rdata = '0;
            e.lat   = T;
        end
        return e;
    endfunction

    function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input int s, input int w, input kind_e k, input logic [DW-1:0] rd);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.sel = 4'hF; t.s = s; t.w = w;
        t.kind = k; t.rd = rd; t.noise = 1'b0; t.abort = 1'b0;
        return t;
    endfunction

    task automatic send(input txn_t t);
        exp_t e;
        int   g = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = t.we; cmd_addr = t.addr; cmd_wdata = t.wdata; cmd_sel = t.sel;
        #1;
        while (cmd_ready !== 1'b1 && g < 500) begin
            @(negedge clk); #1; g++;
        end
        if (g >= 500) begin
            fail_now("cmd_accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        slv_q.push_back(t);
        if (!t.abort) begin
            e = model(t);
            e.acc = ecnt + 1;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_we = 1'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 2000) begin
            @(negedge clk); g++;
        end
        if (sb_q.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Slave: follows the plan of the transaction that raised cyc.
    initial begin
        txn_t p;
        exp_t e;
        int   k, ncyc;
        wb.stall = 1'b0; wb.ack = 1'b0; wb.err = 1'b0; wb.rdata = '0;
        forever begin
            @(negedge clk);
            if (wb.cyc === 1'b1) begin
                if (slv_q.size() == 0) begin
                    fail_now("unplanned_cyc");
                    while (wb.cyc === 1'b1) @(negedge clk);
                end else begin
                    p = slv_q.pop_front();
                    e = model(p);
                    k = 0; ncyc = 0;
                    while (wb.cyc === 1'b1 && k < 1000) begin
                        ncyc++;
                        chk("stb", wb.stb, (k <= p.s));
                        if (wb.stb === 1'b1) begin
                            chk("wb_addr", wb.addr, p.addr);
                            chk("wb_we", wb.we, p.we);
                            chk("wb_sel", wb.sel, p.sel);
                            chk("wb_wdata", wb.wdata, p.wdata);
                        end
                        wb.stall = (k < p.s);
                        wb.ack   = (k < p.s) && p.noise;
                        wb.err   = 1'b0;
                        wb.rdata = $urandom;
                        if (k == p.s + p.w) begin
                            case (p.kind)
                                K_ACK:  begin wb.ack = 1'b1; wb.rdata = p.rd; end
                                K_ERR:  wb.err = 1'b1;
                                K_BOTH: begin wb.ack = 1'b1; wb.err = 1'b1; wb.rdata = p.rd; end
                                default: ;
                            endcase
                        end
                        @(negedge clk);
                        k++;
                    end
                    wb.stall = 1'b0; wb.ack = 1'b0; wb.err = 1'b0;
                    if (!p.abort) chk("cyc_cycles", ncyc, e.lat);
                end
            end else begin
                wb.stall = 1'b0; wb.ack = stray; wb.err = 1'b0; wb.rdata = $urandom;
            end
        end
    end

    // Monitor: drives rsp_ready, checks latency on first valid, fields on handshake.
    initial begin
        bit   prev_v = 1'b0, hs_pend = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            case (rr_mode)
                0:       rsp_ready = 1'($urandom_range(0, 1));
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
            if (rst === 1'b1) begin
                prev_v = 1'b0; hs_pend = 1'b0;
            end else begin
                if (hs_pend) chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
                hs_pend = 1'b0;
                if (rsp_valid === 1'b1) begin
                    chk("rsp_bus_idle", wb.cyc, 1'b0);
                    chk("rsp_cmd_ready", cmd_ready, 1'b0);
                    if (sb_q.size() == 0) begin
                        if (!prev_v) fail_now("unexpected_rsp");
                    end else begin
                        e = sb_q[0];
                        if (!prev_v) chk("latency", ecnt - e.acc, e.lat);
                        if (rsp_ready) begin
                            chk("rsp_rdata", rsp_rdata, e.rdata);
                            chk("rsp_err", rsp_err, e.err);
                            chk("rsp_timeout", rsp_timeout, e.to);
                            void'(sb_q.pop_front());
                            hs_pend = 1'b1;
                        end
                    end
                end
                prev_v = (rsp_valid === 1'b1);
            end
        end
    end

    initial begin
        txn_t t;
        int   g;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_cyc", wb.cyc, 1'b0);
        chk("rst_stb", wb.stb, 1'b0);
        chk("rst_we", wb.we, 1'b0);
        chk("rst_sel", wb.sel, '0);
        chk("rst_addr", wb.addr, '0);
        chk("rst_wdata", wb.wdata, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        rr_mode = 2;

        send(mk(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, K_ACK, 32'h0));
        send(mk(1'b0, 32'h20, 32'h0, 3, 2, K_ACK, 32'h12345678));
        send(mk(1'b0, 32'h24, 32'h0, 0, 1, K_BOTH, 32'hCAFEF00D));
        send(mk(1'b0, 32'h28, 32'h0, 3, 4, K_ACK, 32'hA5A5A5A5));   // ack on the limit edge
        send(mk(1'b0, 32'h2C, 32'h0, 4, 4, K_ACK, 32'h5A5A5A5A));   // one edge too late
        send(mk(1'b0, 32'h30, 32'h0, 0, 0, K_NONE, 32'h0));
        drain();

        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ack_no_rsp", rsp_valid, 1'b0);
        end

        rr_mode = 1;
        send(mk(1'b1, 32'h40, 32'h11112222, 0, 0, K_ACK, 32'h0));
        g = 0;
        while (rsp_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        if (rsp_valid !== 1'b1) fail_now("held_rsp_never_valid");
        fork
            send(mk(1'b0, 32'h44, 32'h0, 1, 1, K_ACK, 32'h0BADBEEF));
            begin
                repeat (5) begin
                    @(negedge clk); #2;
                    chk("held_cmd_ready", cmd_ready, 1'b0);
                    chk("held_cyc", wb.cyc, 1'b0);
                end
                rr_mode = 2;
            end
        join
        drain();

        t = mk(1'b0, 32'h50, 32'h0, 0, 50, K_NONE, 32'h0);
        t.abort = 1'b1;
        send(t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cyc", wb.cyc, 1'b0);
        chk("rst_mid_stb", wb.stb, 1'b0);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);

        rr_mode = 0;
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 9);
            t = mk(1'($urandom), $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 5),
                   (r == 0) ? K_NONE : (r == 1) ? K_ERR : (r == 2) ? K_BOTH : K_ACK, $urandom);
            t.sel   = 4'($urandom);
            t.noise = 1'($urandom);
            send(t);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rr_mode = 2;
        drain();
        chk("slave_plans_left", slv_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
